lc3_control_fsm: RTL and testbench

- Multi-cycle control unit that sequences the 16-bit LC-3-style datapath (PC, RegFile, EAB, MARMUX, ALU, IR, NZP, Memory, tri-state bus).
- Decodes IR[15:12], drives every datapath select, load, write and bus-enable, and evaluates branch conditions from N/Z/P.
- Sits beside the datapath at top level; the only inputs it takes from the datapath are IR and NZP.

---
 rtl/lc3_pkg.sv | 91 +++++++++
 rtl/lc3_ctrl_decode.sv | 140 ++++++++++++++
 rtl/lc3_control_fsm.sv | 150 +++++++++++++++
 tb/tb_lc3_control_fsm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: opcodes, FSM state encodings, the
// datapath mux select encodings and the control-vector struct that the
// decoder hands to the FSM top.
package lc3_pkg;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // EXEC is shared by all single-cycle ops (ALU, BR, JMP, LEA); the
  // decoder picks the strobes from the opcode.
  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH0 = 5'd1,
    S_FETCH1 = 5'd2,
    S_FETCH2 = 5'd3,
    S_DECODE = 5'd4,
    S_EXEC   = 5'd5,
    S_JSR0   = 5'd6,
    S_JSR1   = 5'd7,
    S_ADDR   = 5'd8,
    S_MEMRD  = 5'd9,
    S_IND    = 5'd10,
    S_WB     = 5'd11,
    S_SDATA  = 5'd12,
    S_SWR    = 5'd13,
    S_HALT   = 5'd14
  } state_e;

  // selPC
  localparam logic [1:0] SELPC_INC = 2'b00;
  localparam logic [1:0] SELPC_EAB = 2'b01;
  localparam logic [1:0] SELPC_BUS = 2'b10;
  // selEAB2
  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;
  // aluControl
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;
  // selMDR
  localparam logic SELMDR_BUS = 1'b0;
  localparam logic SELMDR_MEM = 1'b1;

  typedef struct packed {
    logic       selMAR;
    logic [1:0] selPC;
    logic       selEAB1;
    logic [1:0] selEAB2;
    logic [1:0] aluControl;
    logic       selMDR;
    logic [2:0] DR;
    logic [2:0] SR1;
    logic [2:0] SR2;
    logic       ldPC;
    logic       ldIR;
    logic       ldMAR;
    logic       ldMDR;
    logic       regWE;
    logic       flagWE;
    logic       memWE;
    logic       enaMARM;
    logic       enaPC;
    logic       enaALU;
    logic       enaMDR;
    logic       halted;
  } ctrl_t;

  // LDR/STR form their address from a base register, the rest from PC.
  function automatic logic is_base_reg(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Purely combinational map from (state, IR, N/Z/P, memory-ready) to the
// full datapath control vector.
//   state_i    : current FSM state
//   ir_i       : instruction register
//   n_i/z_i/p_i: condition flags
//   mem_done_i : last cycle of a FETCH1/MEMRD wait
//   ctrl_o     : control vector (selects, loads, writes, bus enables)
module lc3_ctrl_decode
  import lc3_pkg::*;
(
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  input  logic        n_i,
  input  logic        z_i,
  input  logic        p_i,
  input  logic        mem_done_i,
  output ctrl_t       ctrl_o
);

  logic [3:0] op;
  logic       br_taken;
  // IR[5:3] (imm flag / imm5 high bits) is consumed by the datapath only
  logic       unused_ir;

  assign op        = ir_i[15:12];
  assign br_taken  = (ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i);
  assign unused_ir = ^ir_i[5:3];

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH0: begin
        ctrl_o.enaPC = 1'b1;
        ctrl_o.ldMAR = 1'b1;
        ctrl_o.selPC = SELPC_INC;
        ctrl_o.ldPC  = 1'b1;
      end
      S_FETCH1, S_MEMRD: begin
        ctrl_o.selMDR = SELMDR_MEM;
        ctrl_o.ldMDR  = mem_done_i;
      end
      S_FETCH2: begin
        ctrl_o.enaMDR = 1'b1;
        ctrl_o.ldIR   = 1'b1;
      end
      S_EXEC: begin
        unique case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            ctrl_o.DR     = ir_i[11:9];
            ctrl_o.SR1    = ir_i[8:6];
            ctrl_o.SR2    = ir_i[2:0];
            ctrl_o.aluControl = (op == OP_ADD) ? ALU_ADD :
                                (op == OP_AND) ? ALU_AND : ALU_NOT;
            ctrl_o.enaALU = 1'b1;
            ctrl_o.regWE  = 1'b1;
            ctrl_o.flagWE = 1'b1;
          end
          OP_BR: begin
            if (br_taken) begin
              ctrl_o.selEAB1 = 1'b0;
              ctrl_o.selEAB2 = EAB2_OFF9;
              ctrl_o.selPC   = SELPC_EAB;
              ctrl_o.ldPC    = 1'b1;
            end
          end
          OP_JMP: begin
            ctrl_o.SR1     = ir_i[8:6];
            ctrl_o.selEAB1 = 1'b1;
            ctrl_o.selEAB2 = EAB2_ZERO;
            ctrl_o.selPC   = SELPC_EAB;
            ctrl_o.ldPC    = 1'b1;
          end
          OP_LEA: begin
            ctrl_o.selEAB1 = 1'b0;
            ctrl_o.selEAB2 = EAB2_OFF9;
            ctrl_o.selMAR  = 1'b1;
            ctrl_o.enaMARM = 1'b1;
            ctrl_o.DR      = ir_i[11:9];
            ctrl_o.regWE   = 1'b1;
            ctrl_o.flagWE  = 1'b1;
          end
          default: ;
        endcase
      end
      S_JSR0: begin
        ctrl_o.enaPC = 1'b1;
        ctrl_o.DR    = 3'd7;
        ctrl_o.regWE = 1'b1;
      end
      S_JSR1: begin
        // JSRR reads the base register after R7 was overwritten in JSR0,
        // so JSRR R7 lands on the return address.
        if (ir_i[11]) begin
          ctrl_o.selEAB1 = 1'b0;
          ctrl_o.selEAB2 = EAB2_OFF11;
        end else begin
          ctrl_o.selEAB1 = 1'b1;
          ctrl_o.SR1     = ir_i[8:6];
          ctrl_o.selEAB2 = EAB2_ZERO;
        end
        ctrl_o.selPC = SELPC_EAB;
        ctrl_o.ldPC  = 1'b1;
      end
      S_ADDR: begin
        ctrl_o.selMAR  = 1'b1;
        ctrl_o.enaMARM = 1'b1;
        ctrl_o.ldMAR   = 1'b1;
        if (is_base_reg(op)) begin
          ctrl_o.selEAB1 = 1'b1;
          ctrl_o.SR1     = ir_i[8:6];
          ctrl_o.selEAB2 = EAB2_OFF6;
        end else begin
          ctrl_o.selEAB1 = 1'b0;
          ctrl_o.selEAB2 = EAB2_OFF9;
        end
      end
      S_IND: begin
        ctrl_o.enaMDR = 1'b1;
        ctrl_o.ldMAR  = 1'b1;
      end
      S_WB: begin
        ctrl_o.enaMDR = 1'b1;
        ctrl_o.DR     = ir_i[11:9];
        ctrl_o.regWE  = 1'b1;
        ctrl_o.flagWE = 1'b1;
      end
      S_SDATA: begin
        ctrl_o.SR1        = ir_i[11:9];
        ctrl_o.aluControl = ALU_PASS;
        ctrl_o.enaALU     = 1'b1;
        ctrl_o.selMDR     = SELMDR_BUS;
        ctrl_o.ldMDR      = 1'b1;
      end
      S_SWR:  ctrl_o.memWE  = 1'b1;
      S_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 control unit: state register, memory wait counter and
// LDI/STI indirect flag; the control vector comes from lc3_ctrl_decode.
//   clk, reset (async, active-low), run (leave IDLE)
//   IR, N/Z/P          : from datapath
//   sel*/aluControl/DR/SR1/SR2 : datapath mux selects and register addresses
//   ld*/regWE/flagWE/memWE     : load/write strobes
//   ena*                       : bus tri-state enables (at most one high)
//   halted, state              : status / debug
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        selMAR,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic [1:0]  aluControl,
  output logic        selMDR,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic        memWE,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaALU,
  output logic        enaMDR,
  output logic        halted,
  output logic [4:0]  state
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       ind_q, ind_d;
  logic       mem_wait, mem_done;
  logic [3:0] op;
  ctrl_t      ctrl, ctrl_g;

  assign op       = IR[15:12];
  assign mem_wait = (state_q == S_FETCH1) || (state_q == S_MEMRD);
  assign mem_done = mem_wait && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ind_q   <= ind_d;
    end
  end

  // Counter runs only while waiting; any other state zeroes it, so it is
  // already clear on every entry to FETCH1/MEMRD.
  assign wait_d = (mem_wait && !mem_done) ? wait_q + 3'd1 : 3'd0;

  always_comb begin
    state_d = state_q;
    ind_d   = ind_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: if (mem_done) state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        ind_d = 1'b0;
        unique case (op)
          OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_LEA: state_d = S_EXEC;
          OP_JSR:                                        state_d = S_JSR0;
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI:  state_d = S_ADDR;
          default:                                       state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = S_FETCH0;
      S_JSR0:   state_d = S_JSR1;
      S_JSR1:   state_d = S_FETCH0;
      S_ADDR:   state_d = (op == OP_ST || op == OP_STR) ? S_SDATA : S_MEMRD;
      S_MEMRD: begin
        // First pass of LDI/STI fetches the pointer; everything else
        // (including the second LDI pass) has the data.
        if (mem_done)
          state_d = (ind_q || op == OP_LD || op == OP_LDR) ? S_WB : S_IND;
      end
      S_IND: begin
        ind_d   = 1'b1;
        state_d = (op == OP_STI) ? S_SDATA : S_MEMRD;
      end
      S_WB:     state_d = S_FETCH0;
      S_SDATA:  state_d = S_SWR;
      S_SWR:    state_d = S_FETCH0;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  lc3_ctrl_decode u_decode (
    .state_i    (state_q),
    .ir_i       (IR),
    .n_i        (N),
    .z_i        (Z),
    .p_i        (P),
    .mem_done_i (mem_done),
    .ctrl_o     (ctrl)
  );

  // Kill strobes combinationally while reset is low so nothing can fire
  // in the sliver before the state register settles.
  assign ctrl_g = reset ? ctrl : '0;

  assign selMAR     = ctrl_g.selMAR;
  assign selPC      = ctrl_g.selPC;
  assign selEAB1    = ctrl_g.selEAB1;
  assign selEAB2    = ctrl_g.selEAB2;
  assign aluControl = ctrl_g.aluControl;
  assign selMDR     = ctrl_g.selMDR;
  assign DR         = ctrl_g.DR;
  assign SR1        = ctrl_g.SR1;
  assign SR2        = ctrl_g.SR2;
  assign ldPC       = ctrl_g.ldPC;
  assign ldIR       = ctrl_g.ldIR;
  assign ldMAR      = ctrl_g.ldMAR;
  assign ldMDR      = ctrl_g.ldMDR;
  assign regWE      = ctrl_g.regWE;
  assign flagWE     = ctrl_g.flagWE;
  assign memWE      = ctrl_g.memWE;
  assign enaMARM    = ctrl_g.enaMARM;
  assign enaPC      = ctrl_g.enaPC;
  assign enaALU     = ctrl_g.enaALU;
  assign enaMDR     = ctrl_g.enaMDR;
  assign halted     = ctrl_g.halted;
  assign state      = state_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm with MEM_LAT=3.
module tb_lc3_control_fsm;
  import lc3_pkg::*;

  logic        clk, reset, run, N, Z, P;
  logic [15:0] IR;
  logic        selMAR, selEAB1, selMDR;
  logic [1:0]  selPC, selEAB2, aluControl;
  logic [2:0]  DR, SR1, SR2;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, memWE;
  logic        enaMARM, enaPC, enaALU, enaMDR, halted;
  logic [4:0]  state;

  int total = 0;
  int bad   = 0;

  lc3_control_fsm #(.MEM_LAT(3)) dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR), .N(N), .Z(Z), .P(P),
    .selMAR(selMAR), .selPC(selPC), .selEAB1(selEAB1), .selEAB2(selEAB2),
    .aluControl(aluControl), .selMDR(selMDR), .DR(DR), .SR1(SR1), .SR2(SR2),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .regWE(regWE),
    .flagWE(flagWE), .memWE(memWE), .enaMARM(enaMARM), .enaPC(enaPC),
    .enaALU(enaALU), .enaMDR(enaMDR), .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH0 -> FETCH1 x3 -> FETCH2 -> DECODE -> first execute state
  task automatic to_exec();
    repeat (6) tick();
  endtask

  function automatic int ena_cnt();
    return int'(enaMARM) + int'(enaPC) + int'(enaALU) + int'(enaMDR);
  endfunction

  // all strobes/enables packed, for "nothing fires" checks
  function automatic logic [31:0] strobes();
    return {21'd0, ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, memWE,
            enaMARM, enaPC, enaALU, enaMDR};
  endfunction

  initial begin
    state_e ldi_seq [8];
    int     ena_bad;
    int     hcnt;
    ldi_seq = '{S_MEMRD, S_MEMRD, S_MEMRD, S_IND, S_MEMRD, S_MEMRD, S_MEMRD, S_WB};

    reset = 1'b0; run = 1'b0; IR = 16'h0000; N = 0; Z = 0; P = 0;
    #12;
    chk("rst_state", state, S_IDLE);
    chk("rst_strobes", strobes(), 0);
    chk("rst_halted", halted, 0);
    @(posedge clk); #1 reset = 1'b1;
    tick();
    chk("idle_hold", state, S_IDLE);

    // ADD R1,R2,R3 with 3-cycle memory
    IR = 16'h1283; run = 1'b1;
    tick();
    chk("f0_state", state, S_FETCH0);
    chk("f0_str", {enaPC, ldMAR, ldPC, selPC}, {1'b1, 1'b1, 1'b1, 2'b00});
    run = 1'b0;
    tick(); chk("f1_c1", {state, selMDR, ldMDR}, {S_FETCH1, 1'b1, 1'b0});
    tick(); chk("f1_c2", {state, selMDR, ldMDR}, {S_FETCH1, 1'b1, 1'b0});
    tick(); chk("f1_c3", {state, selMDR, ldMDR}, {S_FETCH1, 1'b1, 1'b1});
    tick(); chk("f2", {state, enaMDR, ldIR}, {S_FETCH2, 1'b1, 1'b1});
    tick(); chk("decode", {state, strobes()}, {S_DECODE, 32'd0});
    tick();
    chk("add_regs", {DR, SR1, SR2, aluControl}, {3'd1, 3'd2, 3'd3, 2'b00});
    chk("add_str", {enaALU, regWE, flagWE, ena_cnt()}, {1'b1, 1'b1, 1'b1, 32'd1});

    // BRnp +5, not taken (Z) then taken (N)
    IR = 16'h0A05; Z = 1'b1;
    tick(); chk("ret_f0", state, S_FETCH0);
    to_exec();
    chk("br_nt", {state, strobes()}, {S_EXEC, 32'd0});
    tick();
    Z = 1'b0; N = 1'b1;
    to_exec();
    chk("br_t", {state, selPC, selEAB1, selEAB2, ldPC}, {S_EXEC, 2'b01, 1'b0, 2'b10, 1'b1});
    N = 1'b0;

    // LDI R2
    IR = 16'hA402;
    tick();
    to_exec();
    chk("ldi_addr", {state, selMAR, enaMARM, ldMAR, selEAB1, selEAB2},
        {S_ADDR, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10});
    ena_bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ldi_seq%0d", i), state, ldi_seq[i]);
      if (ena_cnt() > 1) ena_bad++;
    end
    chk("ldi_bus", ena_bad, 0);
    chk("ldi_wb", {DR, enaMDR, regWE, flagWE, ena_cnt()}, {3'd2, 1'b1, 1'b1, 1'b1, 32'd1});

    // STR R3,R1,#2
    IR = 16'h7642;
    tick();
    to_exec();
    chk("str_addr", {state, SR1, selEAB1, selEAB2, ldMAR}, {S_ADDR, 3'd1, 1'b1, 2'b01, 1'b1});
    tick();
    chk("str_sdata", {state, SR1, aluControl, selMDR, ldMDR, enaALU},
        {S_SDATA, 3'd3, 2'b11, 1'b0, 1'b1, 1'b1});
    tick(); chk("str_swr", {state, memWE}, {S_SWR, 1'b1});
    tick(); chk("str_done", {state, memWE}, {S_FETCH0, 1'b0});

    // JSR +3
    IR = 16'h4803;
    to_exec();
    chk("jsr0", {state, DR, enaPC, regWE, ena_cnt()}, {S_JSR0, 3'd7, 1'b1, 1'b1, 32'd1});
    tick();
    chk("jsr1", {state, selEAB1, selEAB2, selPC, ldPC}, {S_JSR1, 1'b0, 2'b11, 2'b01, 1'b1});

    // TRAP -> HALT, sticky even with run high
    IR = 16'hF025; run = 1'b1;
    tick(); chk("jsr_ret", state, S_FETCH0);
    to_exec();
    hcnt = 0;
    for (int i = 0; i < 22; i++) begin
      if (halted && state == S_HALT && strobes() == 0) hcnt++;
      tick();
    end
    chk("halt_hold", hcnt, 22);

    // Reset aborts a store mid-write
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    run = 1'b1; IR = 16'h7642;
    tick(); chk("restart_f0", state, S_FETCH0);
    run = 1'b0;
    to_exec(); tick(); tick();
    chk("swr_again", {state, memWE}, {S_SWR, 1'b1});
    #2 reset = 1'b0;
    #1;
    chk("abort_we", memWE, 0);
    chk("abort_state", state, S_IDLE);
    run = 1'b1;
    @(negedge clk); reset = 1'b1;
    tick();
    chk("post_rst_f0", {state, enaPC, ldMAR, ldPC}, {S_FETCH0, 1'b1, 1'b1, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
